// File: rtl/dmem_bytelane_if.sv
// Request/response and dump-port bundle for dmem_bytelane.
// master = requester/consumer side, slave = memory side.
interface dmem_bytelane_if #(
  parameter int n  = 32,
  parameter int AW = 8
);
  // Access request
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [n-1:0]  req_wdata;

  // Access response (one-cycle pulse, no backpressure)
  logic          rsp_valid;
  logic [n-1:0]  rsp_rdata;
  logic          rsp_err;

  // Full-memory dump stream
  logic          dump_start;
  logic          dump_valid;
  logic          dump_ready;
  logic [AW-1:0] dump_addr;
  logic [7:0]    dump_data;
  logic          dump_last;

  // High while clearing or dumping
  logic          busy;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output dump_start, dump_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  dump_valid, dump_addr, dump_data, dump_last, busy
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  dump_start, dump_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output dump_valid, dump_addr, dump_data, dump_last, busy
  );
endinterface

// File: rtl/dmem_bytelane.sv
// Byte-addressed data memory for the MEM stage: byte/half/word loads and
// stores with alignment/range checking, optional sign extension, a
// self-clearing sweep after reset and a handshaked full-memory dump port.
// n must be 8, 16 or 32; DEPTH a power of two; AW = log2(DEPTH).
module dmem_bytelane #(
  parameter int n     = 32,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic           clk,
  input  logic           reset,
  dmem_bytelane_if.slave bus
);

  localparam int NB = n / 8;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_DUMP
  } state_t;

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic [7:0]    mem [DEPTH];

  logic          accept;
  int            req_bytes;
  logic          req_err;
  logic          load_sign;
  logic [n-1:0]  load_data;
  logic [AW-1:0] dump_next;

  // A pending dump start wins over a same-cycle request.
  assign bus.req_ready = (state == S_IDLE) && !bus.dump_start;
  assign accept        = bus.req_valid && bus.req_ready;
  assign dump_next     = bus.dump_addr + 1'b1;

  // Decode access size and flag illegal, oversize, misaligned or
  // out-of-range requests.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    req_bytes = 1;
    req_err   = 1'b0;
    case (bus.req_size)
      2'd0:    req_bytes = 1;
      2'd1:    req_bytes = 2;
      2'd2:    req_bytes = NB;
      default: begin
        req_bytes = 1;
        req_err   = 1'b1;
      end
    endcase
    if (req_bytes > NB)                                   req_err = 1'b1;
    if ((int'(bus.req_addr) & (req_bytes - 1)) != 0)      req_err = 1'b1;
    if ((int'(bus.req_addr) + req_bytes) > DEPTH)         req_err = 1'b1;
  end

  // Little-endian load assembly with zero or sign fill above the access.
  always_comb begin
    load_sign = bus.req_signed && mem[bus.req_addr + AW'(req_bytes - 1)][7];
    load_data = '0;
    for (int b = 0; b < NB; b++) begin
      if (b < req_bytes) load_data[8*b +: 8] = mem[bus.req_addr + AW'(b)];
      else               load_data[8*b +: 8] = {8{load_sign}};
    end
  end

  // Storage write port: the clear sweep or an accepted, error-free store.
  // NOTE: the array has no reset branch; the CLEAR sweep zeroes it, which
  // keeps it mappable to plain RAM instead of DEPTH x 8 resettable flops.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[clr_cnt] <= 8'h00;
    end else if (accept && bus.req_we && !req_err) begin
      for (int b = 0; b < NB; b++) begin
        if (b < req_bytes) mem[bus.req_addr + AW'(b)] <= bus.req_wdata[8*b +: 8];
      end
    end
  end

  // Control FSM with registered response, dump and busy outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_CLEAR;
      clr_cnt        <= '0;
      bus.busy       <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_rdata  <= '0;
      bus.rsp_err    <= 1'b0;
      bus.dump_valid <= 1'b0;
      bus.dump_addr  <= '0;
      bus.dump_data  <= 8'h00;
      bus.dump_last  <= 1'b0;
    end else begin
      bus.rsp_valid <= accept;
      bus.rsp_err   <= accept && req_err;
      bus.rsp_rdata <= (accept && !bus.req_we && !req_err) ? load_data : '0;

      case (state)
        S_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == AW'(DEPTH - 1)) begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end
        end

        S_IDLE: begin
          if (bus.dump_start) begin
            state          <= S_DUMP;
            bus.busy       <= 1'b1;
            bus.dump_valid <= 1'b1;
            bus.dump_addr  <= '0;
            bus.dump_data  <= mem[0];
            bus.dump_last  <= (DEPTH == 1);
          end
        end

        S_DUMP: begin
          if (bus.dump_valid && bus.dump_ready) begin
            if (bus.dump_last) begin
              state          <= S_IDLE;
              bus.busy       <= 1'b0;
              bus.dump_valid <= 1'b0;
              bus.dump_last  <= 1'b0;
            end else begin
              bus.dump_addr <= dump_next;
              bus.dump_data <= mem[dump_next];
              bus.dump_last <= (dump_next == AW'(DEPTH - 1));
            end
          end
        end

        default: begin
          state    <= S_CLEAR;
          clr_cnt  <= '0;
          bus.busy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed self-checking bench for dmem_bytelane (n=32, DEPTH=256).
module tb_dmem_bytelane;

  logic clk;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] model [256];

  dmem_bytelane_if #(.n(32), .AW(8)) bus ();

  dmem_bytelane #(.n(32), .DEPTH(256), .AW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Releases reset at a negedge and verifies the 256-cycle CLEAR window.
  task automatic release_and_clear(input string tag);
    int bad;
    bad = 0;
    reset = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1) bad++;
      step();
    end
    check({tag, "_ready_low_256"}, bad, 0);
    check({tag, "_ready_257"}, bus.req_ready, 1'b1);
    check({tag, "_busy_257"}, bus.busy, 1'b0);
  endtask

  // One request at a negedge, response checked at the following negedge.
  task automatic access(input string tag, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int nb;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    #1;
    check({tag, "_ready"}, bus.req_ready, 1'b1);
    step();
    bus.req_valid = 1'b0;
    check({tag, "_rsp_valid"}, bus.rsp_valid, 1'b1);
    check({tag, "_rdata"}, bus.rsp_rdata, exp_rdata);
    check({tag, "_err"}, bus.rsp_err, exp_err);
    if (we && !exp_err) begin
      nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      for (int b = 0; b < nb; b++) model[addr + 8'(b)] = wdata[8*b +: 8];
    end
  endtask

  initial begin
    int bad_addr, bad_data, bad_last, bad_stab, bad_rr, beats, cyc, first_lat;
    logic       rdy, prev_stall, prev_last;
    logic [7:0] prev_addr, prev_data, beat12;

    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 8'h00;
    bus.req_wdata  = 32'h0;
    bus.dump_start = 1'b0;
    bus.dump_ready = 1'b0;

    // Reset held three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_busy", bus.busy, 1'b1);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_dump_valid", bus.dump_valid, 1'b0);
    check("rst_dump_last", bus.dump_last, 1'b0);
    check("rst_dump_addr", bus.dump_addr, 8'h00);
    check("rst_dump_data", bus.dump_data, 8'h00);
    release_and_clear("clr1");
    access("ld0", 1'b0, 2'd2, 1'b0, 8'h00, 32'h0, 32'h0000_0000, 1'b0);

    // Store/load sizes
    access("st_w10", 1'b1, 2'd2, 1'b0, 8'h10, 32'h1122_3344, 32'h0, 1'b0);
    access("st_b12", 1'b1, 2'd0, 1'b0, 8'h12, 32'h0000_00AA, 32'h0, 1'b0);
    access("st_h14", 1'b1, 2'd1, 1'b0, 8'h14, 32'h0000_BEEF, 32'h0, 1'b0);
    access("ld_w10", 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 32'h11AA_3344, 1'b0);
    access("ld_h14", 1'b0, 2'd1, 1'b0, 8'h14, 32'h0, 32'h0000_BEEF, 1'b0);
    access("ld_sh14", 1'b0, 2'd1, 1'b1, 8'h14, 32'h0, 32'hFFFF_BEEF, 1'b0);
    access("ld_sb13", 1'b0, 2'd0, 1'b1, 8'h13, 32'h0, 32'h0000_0011, 1'b0);
    access("ld_sb12", 1'b0, 2'd0, 1'b1, 8'h12, 32'h0, 32'hFFFF_FFAA, 1'b0);
    access("ld_b12", 1'b0, 2'd0, 1'b0, 8'h12, 32'h0, 32'h0000_00AA, 1'b0);

    // Error cases, then confirm no write happened
    access("err_ldw11", 1'b0, 2'd2, 1'b0, 8'h11, 32'h0, 32'h0, 1'b1);
    access("err_sth03", 1'b1, 2'd1, 1'b0, 8'h03, 32'h0000_5555, 32'h0, 1'b1);
    access("err_sz3", 1'b1, 2'd3, 1'b0, 8'h10, 32'hFFFF_FFFF, 32'h0, 1'b1);
    access("err_stwFE", 1'b1, 2'd2, 1'b0, 8'hFE, 32'h7777_7777, 32'h0, 1'b1);
    access("chk_h02", 1'b0, 2'd1, 1'b0, 8'h02, 32'h0, 32'h0, 1'b0);
    access("chk_w10", 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 32'h11AA_3344, 1'b0);
    access("chk_hFE", 1'b0, 2'd1, 1'b0, 8'hFE, 32'h0, 32'h0, 1'b0);
    access("top_wFC", 1'b1, 2'd2, 1'b0, 8'hFC, 32'h0102_0304, 32'h0, 1'b0);
    access("top_sbFF", 1'b0, 2'd0, 1'b1, 8'hFF, 32'h0, 32'h0000_0001, 1'b0);

    // Back-to-back store then load with an idle cycle after
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
    bus.req_signed = 1'b0; bus.req_addr = 8'h20; bus.req_wdata = 32'hCAFE_F00D;
    step();
    check("b2b_st_valid", bus.rsp_valid, 1'b1);
    check("b2b_st_err", bus.rsp_err, 1'b0);
    bus.req_we = 1'b0; bus.req_wdata = 32'h0;
    step();
    bus.req_valid = 1'b0;
    check("b2b_ld_valid", bus.rsp_valid, 1'b1);
    check("b2b_ld_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
    for (int b = 0; b < 4; b++) model[8'h20 + 8'(b)] = 8'(32'hCAFE_F00D >> (8*b));
    step();
    check("b2b_pulse_end", bus.rsp_valid, 1'b0);

    // Dump with random backpressure
    bus.dump_start = 1'b1;
    #1;
    check("dmp_start_ready", bus.req_ready, 1'b0);
    step();
    bus.dump_start = 1'b0;
    bad_addr = 0; bad_data = 0; bad_last = 0; bad_stab = 0; bad_rr = 0;
    beats = 0; cyc = 1; first_lat = -1; prev_stall = 1'b0;
    prev_addr = 8'h00; prev_data = 8'h00; prev_last = 1'b0; beat12 = 8'h00;
    while (beats < 256 && cyc < 3000) begin
      if (bus.req_ready !== 1'b0) bad_rr++;
      rdy = 1'b0;
      if (bus.dump_valid === 1'b1) begin
        if (first_lat < 0) first_lat = cyc;
        if (prev_stall && (bus.dump_addr !== prev_addr || bus.dump_data !== prev_data ||
                           bus.dump_last !== prev_last)) bad_stab++;
        if (bus.dump_addr !== 8'(beats)) bad_addr++;
        if (bus.dump_data !== model[8'(beats)]) bad_data++;
        if (bus.dump_last !== (beats == 255)) bad_last++;
        if (beats == 8'h12) beat12 = bus.dump_data;
        rdy = 1'($urandom_range(0, 1));
        prev_addr = bus.dump_addr;
        prev_data = bus.dump_data;
        prev_last = bus.dump_last;
        prev_stall = !rdy;
        if (rdy) beats++;
      end
      bus.dump_ready = rdy;
      step();
      cyc++;
    end
    bus.dump_ready = 1'b0;
    check("dmp_beats", beats, 256);
    check("dmp_first_lat_le2", (first_lat >= 1 && first_lat <= 2), 1'b1);
    check("dmp_addr_order", bad_addr, 0);
    check("dmp_data", bad_data, 0);
    check("dmp_last_only_ff", bad_last, 0);
    check("dmp_stable_stall", bad_stab, 0);
    check("dmp_ready_low", bad_rr, 0);
    check("dmp_beat12", beat12, 8'hAA);
    check("dmp_end_ready", bus.req_ready, 1'b1);
    check("dmp_end_busy", bus.busy, 1'b0);
    check("dmp_end_valid", bus.dump_valid, 1'b0);

    // Dump start together with a request, then reset at beat 100
    bus.dump_start = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
    bus.req_addr = 8'h30; bus.req_wdata = 32'h1234_5678;
    #1;
    check("sim_ready_low", bus.req_ready, 1'b0);
    step();
    bus.dump_start = 1'b0;
    bus.req_valid  = 1'b0;
    check("sim_no_rsp", bus.rsp_valid, 1'b0);
    check("sim_dump_valid", bus.dump_valid, 1'b1);
    bus.dump_ready = 1'b1;
    for (int c = 0; c < 400 && !(bus.dump_valid === 1'b1 && bus.dump_addr === 8'd100); c++) step();
    check("sim_at_beat100", bus.dump_addr, 8'd100);
    reset = 1'b1;
    step();
    bus.dump_ready = 1'b0;
    check("mid_rst_busy", bus.busy, 1'b1);
    check("mid_rst_dump_valid", bus.dump_valid, 1'b0);
    check("mid_rst_dump_addr", bus.dump_addr, 8'h00);
    check("mid_rst_ready", bus.req_ready, 1'b0);
    release_and_clear("clr2");
    access("post_ld10", 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 32'h0, 1'b0);
    access("post_ld30", 1'b0, 2'd2, 1'b0, 8'h30, 32'h0, 32'h0, 1'b0);
    access("post_ld20", 1'b0, 2'd2, 1'b0, 8'h20, 32'h0, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
